// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider producing outclk with a period of cur_div refclk cycles.
// Divisor updates are double-buffered and only take effect at a period boundary.
module clock_divider_prog #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 50000000
) (
  input  logic             refclk,
  input  logic             resetn,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             outclk,
  output logic             tick,
  output logic [WIDTH-1:0] cur_div,
  output logic             pending
);

  localparam logic [WIDTH-1:0] MIN_DIV   = WIDTH'(2);
  localparam logic [WIDTH-1:0] RESET_DIV = (DEFAULT_DIV < 2) ? MIN_DIV : WIDTH'(DEFAULT_DIV);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             outclk_q, outclk_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] cur_div_q, cur_div_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;
  logic             pending_q, pending_d;

  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] high_len;
  logic             at_boundary;
  logic             period_start;

  function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] v);
    return (v < MIN_DIV) ? MIN_DIV : v;
  endfunction

  // cnt never exceeds cur_div-1, so the increment cannot wrap.
  assign cnt_inc     = cnt_q + WIDTH'(1);
  assign high_len    = cur_div_q - (cur_div_q >> 1);
  assign at_boundary = (cnt_q == (cur_div_q - WIDTH'(1)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    outclk_d     = outclk_q;
    tick_d       = 1'b0;
    cur_div_d    = cur_div_q;
    pend_div_d   = pend_div_q;
    pending_d    = pending_q;
    period_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d      = ST_RUN;
          period_start = 1'b1;
        end else begin
          cnt_d    = '0;
          outclk_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          outclk_d = 1'b0;
        end else if (at_boundary) begin
          period_start = 1'b1;
        end else begin
          cnt_d    = cnt_inc;
          outclk_d = (cnt_inc < high_len);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        outclk_d = 1'b0;
      end
    endcase

    // A load coinciding with a period start bypasses the pending register.
    if (period_start) begin
      cnt_d    = '0;
      outclk_d = 1'b1;
      tick_d   = 1'b1;
      if (div_load) begin
        cur_div_d = clamp_div(div_in);
        pending_d = 1'b0;
      end else if (pending_q) begin
        cur_div_d = pend_div_q;
        pending_d = 1'b0;
      end
    end else if (div_load) begin
      pend_div_d = clamp_div(div_in);
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge refclk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      outclk_q   <= 1'b0;
      tick_q     <= 1'b0;
      cur_div_q  <= RESET_DIV;
      pend_div_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      outclk_q   <= outclk_d;
      tick_q     <= tick_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pending_q  <= pending_d;
    end
  end

  assign outclk  = outclk_q;
  assign tick    = tick_q;
  assign cur_div = cur_div_q;
  assign pending = pending_q;

endmodule

// File: doc/clock_divider_prog.md
Name: clock_divider_prog

Overview:
- Runtime-programmable clock divider with enable, odd-divisor support and a period-start strobe.
- Generates `outclk` with period of N `refclk` cycles, where N is loaded at runtime.
- Divisor changes are double-buffered and take effect only at a period boundary, so `outclk` never glitches.
- Used as the slow-clock / tick source for display scanning, single-step and timer logic.

Parameters:
- WIDTH, 32, width of divisor and internal counter.
- DEFAULT_DIV, 50000000, divisor active after reset; values below 2 are clamped to 2.

Ports:
- refclk  input  1  reference clock; all logic on its rising edge.
- resetn  input  1  asynchronous active-low reset.
- enable  input  1  1 = run; 0 = hold the divider idle.
- div_in  input  WIDTH  new divisor value N.
- div_load  input  1  one-cycle strobe; captures `div_in` into the pending register.
- outclk  output  1  divided clock, registered.
- tick  output  1  one-`refclk` pulse coincident with each `outclk` rising edge.
- cur_div  output  WIDTH  divisor currently in effect (clamped).
- pending  output  1  a loaded divisor is waiting for the next period boundary.

Behaviour:
- Reset (asynchronous, resetn=0):
  - cnt=0, outclk=0, tick=0, started=0, pending=0.
  - cur_div=max(DEFAULT_DIV,2); pend_div=0.
- Clamp rule: any divisor value <2 (from `DEFAULT_DIV` or `div_in`) becomes 2. Clamping happens at capture into `pend_div`.
- Duty cycle, for N=cur_div:
  - H = N - floor(N/2) (ceiling of N/2).
  - `outclk` is high while cnt in 0..H-1 and low while cnt in H..N-1.
  - Odd N is therefore high one cycle longer than low, e.g. N=5 gives 3 high, 2 low.
- Idle (enable=0): cnt<=0, outclk<=0, tick<=0, started<=0. cur_div and pending are unchanged.
- Start (enable=1, started=0): started<=1, cnt<=0, outclk<=1, tick<=1. A boundary update is applied (see below).
- Run, not at boundary (started=1, cnt!=cur_div-1): cnt<=cnt+1, outclk<=(cnt+1<H), tick<=0.
- Boundary (started=1, cnt==cur_div-1): cnt<=0, outclk<=1, tick<=1. A boundary update is applied.
- Boundary update: if pending=1, cur_div<=pend_div and pending<=0. The new N governs the period that starts on that edge.
- div_load:
  - pend_div<=clamp(div_in), pending<=1.
  - A later load before the boundary overwrites the earlier one; last write wins.
- div_load on the same edge as a Start/Boundary: the `div_in` value is used directly for the period starting on that edge (bypass); pending stays 0.
- Enable dropped mid-period: on the next edge `outclk` goes low and cnt clears. On re-enable a full fresh period starts with a tick.
- Width: cnt is WIDTH bits. Compare in WIDTH bits; no overflow is possible since cnt ≤ cur_div-1.
- Latency:
  - `outclk`/`tick` are registered, so the first high appears one edge after enable is sampled high.
  - A loaded divisor is visible on `cur_div` one edge after the boundary it applies at.
- Reset mid-operation forces all reset values immediately, independent of `refclk`.

Test Plan:
- DEFAULT_DIV=4, enable held 1 after reset → `outclk` pattern 1,1,0,0 repeating. `tick` high on cnt=0 edges, every 4 cycles. cur_div=4.
- Load div_in=5 mid-period (cnt=1) → pending=1. The current 4-cycle period completes, then `outclk` follows 1,1,1,0,0. cur_div=5 and pending=0 after the boundary.
- Load div_in=0 → clamped to 2; `outclk` toggles every cycle (1,0,1,0), tick every 2 cycles. Load div_in=1 → same result.
- Two loads (6 then 3) within one period → only 3 is applied at the boundary. Load exactly on a boundary edge → that value applies to the period starting on that edge, pending stays 0.
- Drop enable at cnt=2 → next edge outclk=0, tick=0, cnt=0. Re-enable → tick=1, outclk=1 on the first edge, full period follows.
- Assert resetn=0 asynchronously mid-high-phase → outclk=0 and tick=0 immediately; cur_div returns to DEFAULT_DIV and pending clears.
